// File: rtl/cp0_count_timer_if.sv
// cp0_count_timer_if
// Bundles the software-facing signals of the CP0 Count/timer block.
//   master : CP0 side. Drives the Count write, the Compare value, the
//            Compare write strobe and halt. Reads Count, tick and timer_int.
//   slave  : the timer itself (cp0_count_timer).
// Ports carried:
//   count_we, write_data   MTC0 Count write strobe and data
//   compare_val            current Compare value from compare_unit
//   compare_we             Compare was written this cycle
//   halt                   freeze Count
//   count_rd               registered Count value
//   tick                   one-cycle pulse on each Count increment
//   timer_int              level timer interrupt request (IP7)
interface cp0_count_timer_if #(
  parameter int WIDTH = 32
);
  logic             count_we;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] compare_val;
  logic             compare_we;
  logic             halt;
  logic [WIDTH-1:0] count_rd;
  logic             tick;
  logic             timer_int;

  modport master (
    output count_we, write_data, compare_val, compare_we, halt,
    input  count_rd, tick, timer_int
  );

  modport slave (
    input  count_we, write_data, compare_val, compare_we, halt,
    output count_rd, tick, timer_int
  );
endinterface

// File: rtl/cp0_count_timer.sv
// cp0_count_timer
// CP0 Count register and timer interrupt source. It sits beside compare_unit.
// Count advances once every COUNT_DIV clocks. Software can write Count directly.
// A rising match of Count against Compare raises timer_int. timer_int stays
// high until software rewrites Compare.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of cp0_count_timer_if. It carries count_we,
//        write_data, compare_val, compare_we and halt in, and count_rd,
//        tick and timer_int out. All outputs are registered.
module cp0_count_timer #(
  parameter int WIDTH     = 32,
  parameter int COUNT_DIV = 2
) (
  input logic             clk,
  input logic             rst,
  cp0_count_timer_if.slave bus
);

  localparam int                DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } int_state_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic             match_prev_q, match_prev_d;
  int_state_e       state_q, state_d;
  logic             timer_int_q, timer_int_d;
  logic             match_s;
  logic             rise_s;

  // Count and prescaler next state. A Count write beats halt, and halt beats the increment.
  always_comb begin
    count_d   = count_q;
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;
    if (bus.count_we) begin
      count_d   = bus.write_data;
      div_cnt_d = '0;
    end else if (bus.halt) begin
      count_d   = count_q;
      div_cnt_d = div_cnt_q;
    end else if (div_cnt_q == DIV_LAST) begin
      // Count wraps modulo 2^WIDTH, with no carry out.
      count_d   = count_q + WIDTH'(1);
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Match edge detection. Only the first cycle of equality counts as a rise,
  // so a frozen or still-equal Count cannot raise the interrupt twice.
  always_comb begin
    match_s      = (count_q == bus.compare_val);
    rise_s       = match_s & ~match_prev_q;
    match_prev_d = match_s;
  end

  // Interrupt FSM next state. A Compare write beats a rise in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s && !bus.compare_we) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (bus.compare_we) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    timer_int_d = (state_d == ST_PEND);
  end

  // State registers. match_prev resets to 1 so that Count=0 against Compare=0
  // does not fire straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      div_cnt_q    <= '0;
      tick_q       <= 1'b0;
      match_prev_q <= 1'b1;
      state_q      <= ST_IDLE;
      timer_int_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_cnt_q    <= div_cnt_d;
      tick_q       <= tick_d;
      match_prev_q <= match_prev_d;
      state_q      <= state_d;
      timer_int_q  <= timer_int_d;
    end
  end

  assign bus.count_rd  = count_q;
  assign bus.tick      = tick_q;
  assign bus.timer_int = timer_int_q;

endmodule

// File: tb/tb_cp0_count_timer.sv
module tb_cp0_count_timer;

  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_count_timer_if #(.WIDTH(32)) bus_if ();

  cp0_count_timer #(.WIDTH(32), .COUNT_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model. It is a cycle-level description of the specified behaviour:
  // count value, prescale phase, "was equal last cycle", and the pending flag.
  logic [31:0] m_count = 32'd0;
  int          m_phase = 0;
  bit          m_tick  = 1'b0;
  bit          m_int   = 1'b0;
  bit          m_prev_eq = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit eq;
    if (rst) begin
      m_count = 32'd0; m_phase = 0; m_tick = 1'b0; m_int = 1'b0; m_prev_eq = 1'b1;
    end else begin
      eq = (m_count == bus_if.compare_val);
      // Compare write always clears; otherwise a fresh equality sets pending.
      m_int = bus_if.compare_we ? 1'b0 : (m_int | (eq & ~m_prev_eq));
      m_prev_eq = eq;
      m_tick = 1'b0;
      if (bus_if.count_we) begin
        m_count = bus_if.write_data; m_phase = 0;
      end else if (!bus_if.halt) begin
        if (m_phase == DIV - 1) begin
          m_count = m_count + 32'd1; m_phase = 0; m_tick = 1'b1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", bus_if.count_rd, m_count);
      check("model_tick", {31'd0, bus_if.tick}, {31'd0, m_tick});
      check("model_int", {31'd0, bus_if.timer_int}, {31'd0, m_int});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.count_we = 1'b0; bus_if.write_data = 32'd0; bus_if.compare_val = 32'd0;
    bus_if.compare_we = 1'b0; bus_if.halt = 1'b0;

    // Reset, then free run
    step(1); chk_en = 1'b1;
    step(1);
    check("rst_count", bus_if.count_rd, 32'd0);
    check("rst_tick", {31'd0, bus_if.tick}, 32'd0);
    check("rst_int", {31'd0, bus_if.timer_int}, 32'd0);
    rst = 1'b0;
    step(1);
    check("release_int", {31'd0, bus_if.timer_int}, 32'd0);
    step(8);
    check("run_tick_odd", {31'd0, bus_if.tick}, 32'd0);
    step(1);
    check("run_count10", bus_if.count_rd, 32'd5);
    check("run_tick_even", {31'd0, bus_if.tick}, 32'd1);

    // Match at compare 3
    rst = 1'b1; bus_if.compare_val = 32'd3;
    step(1); rst = 1'b0;
    step(6);
    check("match_count3", bus_if.count_rd, 32'd3);
    check("match_int_early", {31'd0, bus_if.timer_int}, 32'd0);
    step(1);
    check("match_int_set", {31'd0, bus_if.timer_int}, 32'd1);
    step(9);
    check("match_count8", bus_if.count_rd, 32'd8);
    check("match_int_held", {31'd0, bus_if.timer_int}, 32'd1);
    bus_if.compare_we = 1'b1;
    step(1); bus_if.compare_we = 1'b0;
    check("match_int_clear", {31'd0, bus_if.timer_int}, 32'd0);

    // Wrap through zero
    bus_if.count_we = 1'b1; bus_if.write_data = 32'hFFFF_FFFE; bus_if.compare_val = 32'd0;
    step(1); bus_if.count_we = 1'b0;
    check("wrap_load", bus_if.count_rd, 32'hFFFF_FFFE);
    step(4);
    check("wrap_zero", bus_if.count_rd, 32'd0);
    check("wrap_int_early", {31'd0, bus_if.timer_int}, 32'd0);
    step(1);
    check("wrap_int_set", {31'd0, bus_if.timer_int}, 32'd1);

    // Halt at a match
    bus_if.count_we = 1'b1; bus_if.write_data = 32'h0F; bus_if.compare_val = 32'h10;
    bus_if.compare_we = 1'b1;
    step(1); bus_if.count_we = 1'b0; bus_if.compare_we = 1'b0;
    check("halt_load", bus_if.count_rd, 32'h0F);
    check("halt_int_cleared", {31'd0, bus_if.timer_int}, 32'd0);
    step(2);
    check("halt_reach", bus_if.count_rd, 32'h10);
    bus_if.halt = 1'b1;
    step(1);
    check("halt_int_set", {31'd0, bus_if.timer_int}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("halt_hold", bus_if.count_rd, 32'h10);
      check("halt_no_tick", {31'd0, bus_if.tick}, 32'd0);
    end
    bus_if.compare_we = 1'b1;
    step(1); bus_if.compare_we = 1'b0;
    check("halt_clear", {31'd0, bus_if.timer_int}, 32'd0);
    step(3);
    check("halt_no_refire", {31'd0, bus_if.timer_int}, 32'd0);
    check("halt_still", bus_if.count_rd, 32'h10);
    bus_if.halt = 1'b0;

    // Clear collides with rise
    bus_if.count_we = 1'b1; bus_if.write_data = 32'h100; bus_if.compare_val = 32'h100;
    step(1); bus_if.count_we = 1'b0; bus_if.compare_we = 1'b1;
    check("coll_pre", {31'd0, bus_if.timer_int}, 32'd0);
    step(1); bus_if.compare_we = 1'b0;
    check("coll_int", {31'd0, bus_if.timer_int}, 32'd0);
    step(2);
    check("coll_int_later", {31'd0, bus_if.timer_int}, 32'd0);

    // Reset while pending
    bus_if.count_we = 1'b1; bus_if.write_data = 32'h200; bus_if.compare_val = 32'h200;
    step(1); bus_if.count_we = 1'b0;
    step(1);
    check("rst_pend_int", {31'd0, bus_if.timer_int}, 32'd1);
    rst = 1'b1;
    step(1); rst = 1'b0;
    check("rst_mid_int", {31'd0, bus_if.timer_int}, 32'd0);
    check("rst_mid_count", bus_if.count_rd, 32'd0);
    step(4);
    check("rst_after_run", bus_if.count_rd, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
